// File: rtl/ks_stream_gen.sv
// Round-key stream generator: latches a 128/192/256-bit master key on start,
// then streams NR round keys over a valid/ready handshake, rotating the key
// left by ROT within its effective width after every accepted key.
module ks_stream_gen #(
  parameter int KWIDTHMAX = 256,
  parameter int RKWIDTH   = 64,
  parameter int ROT       = 15,
  parameter int NR128     = 18,
  parameter int NR256     = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           kWidth,
  input  logic [KWIDTHMAX-1:0] k,
  input  logic                 abort,
  output logic [RKWIDTH-1:0]   rk_data,
  output logic [7:0]           rk_round,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [7:0] NR128_L = 8'(NR128);
  localparam logic [7:0] NR256_L = 8'(NR256);
  localparam logic [KWIDTHMAX-1:0] MASK128 = {{(KWIDTHMAX-128){1'b0}}, {128{1'b1}}};
  localparam logic [KWIDTHMAX-1:0] MASK192 = {{(KWIDTHMAX-192){1'b0}}, {192{1'b1}}};

  state_e                 state_q, state_d;
  logic [1:0]             wsel_q, wsel_d;   // width code of the latched key
  logic [KWIDTHMAX-1:0]   key_q, key_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [7:0]             nr_q, nr_d;
  logic                   err_q, err_d;

  logic [KWIDTHMAX-1:0]   key_rot;
  logic [KWIDTHMAX-1:0]   load_mask;
  logic [RKWIDTH-1:0]     key_top;
  logic                   run;

  // Rotation within the effective width; bits above W are always zero in
  // key_q, so the right shift only pulls down the top ROT bits of the field.
  always_comb begin
    key_rot = '0;
    case (wsel_q)
      2'b00:   key_rot = ((key_q << ROT) | (key_q >> (128 - ROT))) & MASK128;
      2'b01:   key_rot = ((key_q << ROT) | (key_q >> (192 - ROT))) & MASK192;
      default: key_rot = (key_q << ROT) | (key_q >> (256 - ROT));
    endcase
  end

  // Top RKWIDTH bits of the effective key field, and the load mask for k.
  always_comb begin
    key_top   = key_q[255 -: RKWIDTH];
    load_mask = '1;
    case (wsel_q)
      2'b00:   key_top = key_q[127 -: RKWIDTH];
      2'b01:   key_top = key_q[191 -: RKWIDTH];
      default: key_top = key_q[255 -: RKWIDTH];
    endcase
    case (kWidth)
      2'b00:   load_mask = MASK128;
      2'b01:   load_mask = MASK192;
      default: load_mask = '1;
    endcase
  end

  // Next-state and datapath update; abort wins over a same-cycle handshake.
  always_comb begin
    state_d = state_q;
    wsel_d  = wsel_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    nr_d    = nr_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (kWidth == 2'b11) begin
            err_d = 1'b1;
          end else begin
            state_d = S_RUN;
            wsel_d  = kWidth;
            key_d   = k & load_mask;
            cnt_d   = 8'd0;
            nr_d    = (kWidth == 2'b00) ? NR128_L : NR256_L;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (rk_ready) begin
          key_d = key_rot;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == nr_q - 8'd1) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Key, counter, round limit and error pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wsel_q <= 2'b00;
      key_q  <= '0;
      cnt_q  <= 8'd0;
      nr_q   <= 8'd0;
      err_q  <= 1'b0;
    end else begin
      wsel_q <= wsel_d;
      key_q  <= key_d;
      cnt_q  <= cnt_d;
      nr_q   <= nr_d;
      err_q  <= err_d;
    end
  end

  assign run      = (state_q == S_RUN);
  assign rk_valid = run;
  assign busy     = run;
  assign done     = (state_q == S_DONE);
  assign err      = err_q;
  assign rk_data  = run ? (key_top ^ RKWIDTH'(cnt_q)) : '0;
  assign rk_round = run ? cnt_q : 8'd0;

endmodule
